// File: rtl/sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter
//
// Shares the single SD command-issue path between the Wishbone host register
// write and the descriptor-driven data master. Requests are latched, one is
// picked with round-robin priority, presented to the command master as a
// one-cycle start pulse with stable setting/argument, and the arbiter then
// waits for completion (or a programmable timeout) before granting again.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   sw_rst_i                  synchronous soft reset
//   host_req_i/set_i/arg_i    host command write (one-cycle pulse + payload)
//   host_busy_o               host command pending or in flight
//   dm_req_i/set_i/arg_i      data-master request level + payload
//   dm_ack_o                  one-cycle accept pulse to the data master
//   cmd_start_o/set_o/arg_o   start pulse and held command to command master
//   cmd_done_i                one-cycle completion pulse from command master
//   time_out_i                completion timeout in cycles, 0 disables
//   timeout_o                 one-cycle pulse when completion timed out
//   owner_o                   owner of current/last command (0 host, 1 dm)
//   arb_busy_o                arbiter not idle
// ---------------------------------------------------------------------------
module sd_cmd_arbiter #(
    parameter int TO_W = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            sw_rst_i,
    input  logic            host_req_i,
    input  logic [15:0]     host_set_i,
    input  logic [31:0]     host_arg_i,
    output logic            host_busy_o,
    input  logic            dm_req_i,
    input  logic [15:0]     dm_set_i,
    input  logic [31:0]     dm_arg_i,
    output logic            dm_ack_o,
    output logic            cmd_start_o,
    output logic [15:0]     cmd_set_o,
    output logic [31:0]     cmd_arg_o,
    input  logic            cmd_done_i,
    input  logic [TO_W-1:0] time_out_i,
    output logic            timeout_o,
    output logic            owner_o,
    output logic            arb_busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic            host_pend_q, host_pend_d;
    logic [15:0]     host_set_q, host_set_d;
    logic [31:0]     host_arg_q, host_arg_d;
    logic            last_owner_q, last_owner_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            start_d, ack_d, to_d;
    logic [15:0]     set_d;
    logic [31:0]     arg_d;
    logic            owner_d;
    logic            grant_dm;
    logic            to_hit;

    // Counter runs from 0 on the first WAIT edge, so K WAIT edges end at K-1.
    assign to_hit = (time_out_i != '0) && (cnt_q == (time_out_i - TO_W'(1)));

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        host_pend_d  = host_pend_q;
        host_set_d   = host_set_q;
        host_arg_d   = host_arg_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        start_d      = 1'b0;
        ack_d        = 1'b0;
        to_d         = 1'b0;
        set_d        = cmd_set_o;
        arg_d        = cmd_arg_o;
        owner_d      = owner_o;
        grant_dm     = 1'b0;

        // Host slot: the latest write wins, even while a host command runs.
        if (host_req_i) begin
            host_pend_d = 1'b1;
            host_set_d  = host_set_i;
            host_arg_d  = host_arg_i;
        end

        case (state_q)
            IDLE: begin
                if (host_pend_q || dm_req_i) begin
                    // On a tie the requester that did not own the last
                    // command wins.
                    grant_dm = dm_req_i && (!host_pend_q || !last_owner_q);
                    if (grant_dm) begin
                        set_d        = dm_set_i;
                        arg_d        = dm_arg_i;
                        owner_d      = 1'b1;
                        last_owner_d = 1'b1;
                        ack_d        = 1'b1;
                    end else begin
                        set_d        = host_set_q;
                        arg_d        = host_arg_q;
                        owner_d      = 1'b0;
                        last_owner_d = 1'b0;
                        // A write landing on the grant cycle stays pending.
                        host_pend_d  = host_req_i;
                    end
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cmd_done_i) begin
                    state_d = IDLE;
                end else if (to_hit) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Soft reset overrides everything, including a coincident host write;
        // the issued command registers and the round-robin pointer are kept.
        if (sw_rst_i) begin
            state_d      = IDLE;
            host_pend_d  = 1'b0;
            host_set_d   = host_set_q;
            host_arg_d   = host_arg_q;
            cnt_d        = '0;
            start_d      = 1'b0;
            ack_d        = 1'b0;
            to_d         = 1'b0;
            set_d        = cmd_set_o;
            arg_d        = cmd_arg_o;
            owner_d      = owner_o;
            last_owner_d = last_owner_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            host_pend_q  <= 1'b0;
            host_set_q   <= '0;
            host_arg_q   <= '0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            cmd_start_o  <= 1'b0;
            dm_ack_o     <= 1'b0;
            timeout_o    <= 1'b0;
            cmd_set_o    <= '0;
            cmd_arg_o    <= '0;
            owner_o      <= 1'b0;
        end else begin
            state_q      <= state_d;
            host_pend_q  <= host_pend_d;
            host_set_q   <= host_set_d;
            host_arg_q   <= host_arg_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            cmd_start_o  <= start_d;
            dm_ack_o     <= ack_d;
            timeout_o    <= to_d;
            cmd_set_o    <= set_d;
            cmd_arg_o    <= arg_d;
            owner_o      <= owner_d;
        end
    end

    assign arb_busy_o  = (state_q != IDLE);
    assign host_busy_o = host_pend_q | (!owner_o && (state_q != IDLE));

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_arbiter
//
// Directed stimulus with a scoreboard: each issued request pushes the command
// it should produce; a negedge monitor pops and compares on every start pulse.
// Latency, busy flags, timeout and reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_sd_cmd_arbiter;

    localparam int TO_W = 16;

    typedef struct {
        logic [15:0] set;
        logic [31:0] arg;
        logic        dm;
    } cmd_t;

    logic            clk = 1'b0;
    logic            wb_rst_i;
    logic            sw_rst_i;
    logic            host_req_i;
    logic [15:0]     host_set_i;
    logic [31:0]     host_arg_i;
    logic            host_busy_o;
    logic            dm_req_i;
    logic [15:0]     dm_set_i;
    logic [31:0]     dm_arg_i;
    logic            dm_ack_o;
    logic            cmd_start_o;
    logic [15:0]     cmd_set_o;
    logic [31:0]     cmd_arg_o;
    logic            cmd_done_i;
    logic [TO_W-1:0] time_out_i;
    logic            timeout_o;
    logic            owner_o;
    logic            arb_busy_o;

    cmd_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   starts = 0;
    int   pushed = 0;

    always #5 clk = ~clk;

    sd_cmd_arbiter #(.TO_W(TO_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .sw_rst_i    (sw_rst_i),
        .host_req_i  (host_req_i),
        .host_set_i  (host_set_i),
        .host_arg_i  (host_arg_i),
        .host_busy_o (host_busy_o),
        .dm_req_i    (dm_req_i),
        .dm_set_i    (dm_set_i),
        .dm_arg_i    (dm_arg_i),
        .dm_ack_o    (dm_ack_o),
        .cmd_start_o (cmd_start_o),
        .cmd_set_o   (cmd_set_o),
        .cmd_arg_o   (cmd_arg_o),
        .cmd_done_i  (cmd_done_i),
        .time_out_i  (time_out_i),
        .timeout_o   (timeout_o),
        .owner_o     (owner_o),
        .arb_busy_o  (arb_busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input logic [15:0] s, input logic [31:0] a, input logic dm);
        cmd_t c;
        c.set = s;
        c.arg = a;
        c.dm  = dm;
        exp_q.push_back(c);
        pushed++;
    endtask

    // One-cycle host write; optionally registers the command it should issue.
    task automatic host_write(input logic [15:0] s, input logic [31:0] a, input bit push);
        host_req_i = 1'b1;
        host_set_i = s;
        host_arg_i = a;
        if (push) expect_cmd(s, a, 1'b0);
        tick();
        host_req_i = 1'b0;
    endtask

    task automatic pulse_done();
        cmd_done_i = 1'b1;
        tick();
        cmd_done_i = 1'b0;
    endtask

    task automatic wait_start(input string name, input int exp_lat);
        int n = 0;
        while (!cmd_start_o && n < 8) begin
            tick();
            n++;
        end
        check(name, n, exp_lat);
    endtask

    // Drops the request in the ack cycle so it is seen low on the next edge.
    task automatic wait_dm_ack(input string name, input int exp_lat);
        int n = 0;
        while (!dm_ack_o && n < 8) begin
            tick();
            n++;
        end
        check(name, n, exp_lat);
        dm_req_i = 1'b0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        repeat (2) tick();
        wb_rst_i = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        cmd_t e;
        if (!wb_rst_i && cmd_start_o) begin
            starts++;
            check("start_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cmd_set", cmd_set_o, e.set);
                check("cmd_arg", cmd_arg_o, e.arg);
                check("owner", owner_o, e.dm);
                check("dm_ack_with_start", dm_ack_o, e.dm);
            end
        end else if (!wb_rst_i && dm_ack_o) begin
            check("ack_needs_start", cmd_start_o, 1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int to_cnt;
        int st_before;

        wb_rst_i   = 1'b1;
        sw_rst_i   = 1'b0;
        host_req_i = 1'b0;
        host_set_i = '0;
        host_arg_i = '0;
        dm_req_i   = 1'b0;
        dm_set_i   = '0;
        dm_arg_i   = '0;
        cmd_done_i = 1'b0;
        time_out_i = '0;

        // Reset state.
        tick();
        check("rst_start", cmd_start_o, 0);
        check("rst_set", cmd_set_o, 0);
        check("rst_arg", cmd_arg_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_ack_to", {dm_ack_o, timeout_o}, 0);
        check("rst_busy", {host_busy_o, arb_busy_o}, 0);
        tick();
        wb_rst_i = 1'b0;

        // Single host request, start two cycles after the write.
        host_write(16'h0111, 32'hDEADBEEF, 1);
        check("host_busy_pending", host_busy_o, 1);
        check("arb_idle_pending", arb_busy_o, 0);
        wait_start("host_latency", 1);
        tick();
        check("start_one_cycle", cmd_start_o, 0);
        check("arb_busy_wait", arb_busy_o, 1);
        repeat (3) tick();
        pulse_done();
        check("done_arb_busy", arb_busy_o, 0);
        check("done_host_busy", host_busy_o, 0);
        check("held_arg", cmd_arg_o, 32'hDEADBEEF);

        // Ties after reset: host, then dm, then host wins the second tie.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            host_write(16'h0A01 + 16'(r), 32'h1111_0001 + 32'(r), 1);
            dm_req_i = 1'b1;
            dm_set_i = 16'h0B02 + 16'(r);
            dm_arg_i = 32'h2222_0002 + 32'(r);
            expect_cmd(dm_set_i, dm_arg_i, 1'b1);
            wait_start("tie_host_latency", 1);
            check("tie_host_owner", owner_o, 0);
            repeat (2) tick();
            pulse_done();
            wait_dm_ack("tie_dm_after_done", 1);
            repeat (2) tick();
            check("dm_owned_host_busy", host_busy_o, 0);
            pulse_done();
        end

        // Host overwrite while a dm command is in WAIT.
        dm_req_i = 1'b1;
        dm_set_i = 16'h0C00;
        dm_arg_i = 32'h3333_0000;
        expect_cmd(dm_set_i, dm_arg_i, 1'b1);
        wait_dm_ack("dm_latency", 1);
        tick();
        host_write(16'h0C01, 32'h0000_0001, 0);
        host_write(16'h0C02, 32'h0000_0002, 1);
        check("overwrite_host_busy", host_busy_o, 1);
        tick();
        pulse_done();
        wait_start("overwrite_issue", 1);
        repeat (2) tick();
        pulse_done();
        repeat (5) tick();
        check("overwrite_one_cmd", exp_q.size(), 0);

        // Timeout with K=4.
        time_out_i = 16'd4;
        host_write(16'h0D01, 32'h4444_0001, 1);
        wait_start("to_start", 1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("timeout_edge%0d", k), timeout_o, (k == 4));
        end
        check("timeout_idle", arb_busy_o, 0);
        tick();
        check("timeout_one_cycle", timeout_o, 0);

        // No timeout with time_out_i = 0.
        time_out_i = '0;
        host_write(16'h0D02, 32'h4444_0002, 1);
        wait_start("to0_start", 1);
        to_cnt = 0;
        repeat (1000) begin
            tick();
            if (timeout_o) to_cnt++;
        end
        check("to0_no_timeout", to_cnt, 0);
        check("to0_still_busy", arb_busy_o, 1);
        pulse_done();

        // Done and timeout on the same (3rd) WAIT edge: done wins.
        time_out_i = 16'd3;
        host_write(16'h0D03, 32'h4444_0003, 1);
        wait_start("coll_start", 1);
        tick();
        repeat (2) tick();
        pulse_done();
        check("coll_no_timeout", timeout_o, 0);
        check("coll_idle", arb_busy_o, 0);
        tick();
        check("coll_no_late_timeout", timeout_o, 0);
        time_out_i = '0;

        // Soft reset mid-WAIT with a host command pending; coincident write dropped.
        dm_req_i = 1'b1;
        dm_set_i = 16'h0E01;
        dm_arg_i = 32'h5555_0001;
        expect_cmd(dm_set_i, dm_arg_i, 1'b1);
        wait_dm_ack("sw_dm_latency", 1);
        tick();
        host_write(16'h0E02, 32'h5555_0002, 0);
        check("sw_pend_before", host_busy_o, 1);
        sw_rst_i   = 1'b1;
        host_req_i = 1'b1;
        host_arg_i = 32'h5555_0003;
        tick();
        sw_rst_i   = 1'b0;
        host_req_i = 1'b0;
        check("sw_idle", arb_busy_o, 0);
        check("sw_pend_cleared", host_busy_o, 0);
        check("sw_arg_kept", cmd_arg_o, 32'h5555_0001);
        check("sw_owner_kept", owner_o, 1);
        st_before = starts;
        repeat (10) tick();
        check("sw_no_start", starts, st_before);

        // Asynchronous reset mid-WAIT.
        dm_req_i = 1'b1;
        dm_set_i = 16'h0F01;
        dm_arg_i = 32'h6666_0001;
        expect_cmd(dm_set_i, dm_arg_i, 1'b1);
        wait_dm_ack("async_dm_latency", 1);
        tick();
        check("async_busy_before", arb_busy_o, 1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("async_arg", cmd_arg_o, 0);
        check("async_set", cmd_set_o, 0);
        check("async_owner", owner_o, 0);
        check("async_busy", {arb_busy_o, host_busy_o}, 0);
        check("async_pulses", {cmd_start_o, dm_ack_o, timeout_o}, 0);
        tick();
        wb_rst_i = 1'b0;
        st_before = starts;
        pulse_done();
        repeat (5) tick();
        check("async_done_ignored", {arb_busy_o, timeout_o}, 0);
        check("async_no_start", starts, st_before);

        check("sb_empty", exp_q.size(), 0);
        check("start_count", starts, pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_arbiter.md
# sd_cmd_arbiter

Arbitrates the single SD command-issue path between two requesters. The host side is the Wishbone register file's argument/command write. The data-master side is the descriptor-driven write_req/ack request. The block latches each request, selects one with round-robin priority, and presents it to the command master as a one-cycle start pulse with stable setting and argument. It then tracks completion, or a programmable timeout, before granting again. It sits between the Wishbone register block, the data master and the command master in the SD controller.

## Interface
Parameters:
- TO_W, 16, width of timeout counter and time_out_i

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- sw_rst_i  in  1  synchronous soft reset (software reset register bit 0)
- host_req_i  in  1  one-cycle pulse: host wrote a new command
- host_set_i  in  16  host command setting, valid with host_req_i
- host_arg_i  in  32  host command argument, valid with host_req_i
- host_busy_o  out  1  host command pending or in flight
- dm_req_i  in  1  data-master request level; held until dm_ack_o
- dm_set_i  in  16  data-master command setting, valid while dm_req_i
- dm_arg_i  in  32  data-master argument, valid while dm_req_i
- dm_ack_o  out  1  one-cycle pulse: data-master request accepted
- cmd_start_o  out  1  one-cycle start pulse to the command master
- cmd_set_o  out  16  issued command setting
- cmd_arg_o  out  32  issued command argument
- cmd_done_i  in  1  one-cycle pulse: command master finished
- time_out_i  in  TO_W  completion timeout in cycles; 0 disables
- timeout_o  out  1  one-cycle pulse: completion timed out
- owner_o  out  1  owner of current/last command (0 host, 1 data master)
- arb_busy_o  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT.
- Host slot:
  - host_req_i sets host_pend and latches host_set_i/host_arg_i into the host holding registers.
  - A new host_req_i while host_pend=1 overwrites the slot (latest wins).
  - A host_req_i while a host command is in flight fills the slot for later issue.
- Data-master slot: no storage. dm_req_i itself is the pending flag. dm_set_i/dm_arg_i are captured at grant.
- IDLE arbitration:
  - If exactly one of host_pend or dm_req_i is set, grant it.
  - If both are set, grant the requester not in last_owner (round-robin).
  - On grant: load cmd_set_o/cmd_arg_o from the winner, set owner_o and last_owner, go to ISSUE.
  - A host grant clears host_pend, unless host_req_i is high that same cycle: then host_pend stays set with the new values.
  - A data-master grant pulses dm_ack_o with the ISSUE entry.
- ISSUE: cmd_start_o=1 for exactly this cycle. Clear the timeout counter. Go to WAIT unconditionally. cmd_done_i is ignored here.
- WAIT:
  - cmd_done_i goes to IDLE.
  - Otherwise, the counter increments. If time_out_i != 0 and the counter equals time_out_i-1, pulse timeout_o and go to IDLE.
  - If cmd_done_i and the timeout condition occur in the same cycle, done wins and timeout_o stays 0.
  - With time_out_i=0, WAIT only exits on cmd_done_i.
- cmd_set_o, cmd_arg_o and owner_o hold their values until the next grant.
- Combinational outputs:
  - host_busy_o = host_pend | (owner_o==0 & state!=IDLE)
  - arb_busy_o = (state!=IDLE)
- sw_rst_i has the same effect as reset on state, host_pend, the counter and the pulses. cmd_set_o, cmd_arg_o and owner_o keep their values.
- sw_rst_i has priority over every other event, including a coincident host_req_i, which is dropped.

## Timing
- Reset values: state IDLE, host_pend 0, last_owner 1 (so the host wins the first tie).
- All outputs are 0 at reset, including cmd_set_o, cmd_arg_o and owner_o.
- All outputs are registered except host_busy_o and arb_busy_o.
- Data-master latency: dm_req_i sampled high at edge N in IDLE gives cmd_start_o and dm_ack_o high for the cycle after edge N.
- Host latency: host_req_i sampled at edge N sets host_pend. Grant at edge N+1; cmd_start_o is high for the cycle after N+1.
- Completion: cmd_done_i at edge T returns to IDLE at T. The earliest next cmd_start_o is the cycle after T+1, so there is at least one idle cycle between commands.
- Timeout: with time_out_i=K (K≥1) and no done, timeout_o is high for the cycle after the K-th WAIT edge.
- Data-master handshake: the data master must drop dm_req_i within one cycle of dm_ack_o. The request is not resampled before the next IDLE, which comes at least 2 edges later.
- Reset mid-command: an asynchronous reset immediately forces IDLE with all outputs at their reset values. A later cmd_done_i is ignored.

## Test plan
- Single host request: host_req_i with set=0x0111, arg=0xDEADBEEF.
  - cmd_start_o pulses 2 cycles after the request with those values.
  - cmd_done_i 5 cycles later gives arb_busy_o=0 and host_busy_o=0.
- Simultaneous host and data-master requests after reset:
  - host issues first with owner_o=0.
  - After done, the data master issues with dm_ack_o pulsed and owner_o=1.
  - After a second tie, the host wins again.
- Host overwrite: two host_req_i while a data-master command is in WAIT, args 0x1 then 0x2. After done, exactly one host command is issued with arg 0x2.
- Timeout: time_out_i=4, no cmd_done_i. timeout_o pulses on the 4th WAIT edge and state returns to IDLE.
  - With time_out_i=0 there is no timeout after 1000 cycles.
- Done/timeout collision: time_out_i=3 and cmd_done_i on the 3rd WAIT edge. timeout_o stays 0 and state is IDLE.
- Soft and asynchronous reset mid-WAIT with host_pend=1:
  - sw_rst_i gives IDLE, host_pend=0, no further cmd_start_o; cmd_arg_o is unchanged.
  - wb_rst_i asserted mid-cycle clears all outputs immediately.
